mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8, memory word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-006 cpu_we  input  1  CPU write enable (1 = write, 0 = read).
REQ-007 cpu_addr  input  AW  CPU word address.
REQ-008 cpu_wdata  input  DW  CPU write data.
REQ-009 cpu_rdata  output  DW  CPU read data, valid while cpu_ack = 1.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 dbu_req / dbu_we / dbu_addr / dbu_wdata  input  1/1/AW/DW  debug-unit request, same rules as the CPU port.
REQ-012 dbu_rdata  output  DW; dbu_ack  output  1; same rules as the CPU port.
REQ-013 dbu_hold  input  1  when 1, CPU requests are excluded from arbitration.
REQ-014 mem_addr  output  AW; mem_wdata  output  DW; mem_we  output  1: single-port synchronous memory drive.
REQ-015 mem_rdata  input  DW  memory read data, valid one cycle after mem_addr.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 grant_dbu  output  1  owner of the current access (0 = CPU, 1 = DBU), held from ACCESS through DONE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ACCESS, RESP, DONE.
- IDLE -> ACCESS when any eligible request is present; otherwise stay.
- ACCESS -> RESP, RESP -> DONE, DONE -> IDLE unconditionally.
REQ-019 Eligibility: dbu_req is always eligible; cpu_req is eligible only when dbu_hold = 0.
REQ-020 Tie-break in IDLE: round-robin. Grant the port not granted last; last_grant SHALL update on each grant.
REQ-021 On the IDLE -> ACCESS transition, the winner's we, addr and wdata SHALL be latched; later changes on request inputs do not affect the access.
REQ-022 In ACCESS, mem_addr and mem_wdata SHALL be the latched values, and mem_we SHALL equal the latched we for exactly one cycle.
REQ-023 mem_we SHALL be 0 in all other states and whenever reset = 1; this is gated combinationally.
REQ-024 In RESP, mem_addr SHALL hold the latched address.
- For a read, mem_rdata SHALL be captured into the owner's rdata register at the end of RESP.
- For a write, the owner's rdata register SHALL keep its previous value.
REQ-025 In DONE, the owner's ack SHALL be 1; the other port's ack SHALL be 0. ack is decoded from registered state only (Moore).
REQ-026 Latency: a request first sampled in IDLE at cycle T SHALL receive ack at cycle T+3. Throughput is one access per 4 cycles.
REQ-027 A request still high in the cycle after ack SHALL be treated as a new request.
REQ-028 The non-owner's rdata register SHALL not change during an access.
REQ-029 A request that drops before its grant SHALL be discarded without side effects. Dropping req after the grant SHALL not abort the access.
REQ-030 A change of dbu_hold during ACCESS, RESP or DONE SHALL not affect the current access.
REQ-031 Outside ACCESS and RESP, mem_addr and mem_wdata SHALL hold their last driven values.

Reset
REQ-032 While reset = 1 at a clock edge, the following SHALL be cleared:
- state <= IDLE
- last_grant <= DBU, so the CPU wins the first tie
- grant_dbu <= 0
- cpu_rdata and dbu_rdata <= 0
- latched request registers <= 0
REQ-033 During and after reset, busy, cpu_ack, dbu_ack and mem_we SHALL be 0.
REQ-034 Reset asserted in any state SHALL abort the access: no ack is issued, and no memory write occurs in the reset cycle.

Verification
REQ-035 CPU read: mem[0x10] = 0x12345678; cpu_req = 1, cpu_we = 0, cpu_addr = 0x10 at T -> mem_addr = 0x10 at T+1; cpu_ack = 1 and cpu_rdata = 0x12345678 at T+3; dbu_ack stays 0.
REQ-036 DBU write: dbu_req = 1, dbu_we = 1, dbu_addr = 0x05, dbu_wdata = 0xDEADBEEF -> mem_we = 1 for exactly one cycle, with mem_addr = 0x05 and mem_wdata = 0xDEADBEEF. A later CPU read of 0x05 returns 0xDEADBEEF.
REQ-037 Round-robin: after reset, both ports request continuously -> grant order is CPU, DBU, CPU, DBU; acks are spaced 4 cycles apart.
REQ-038 Hold: dbu_hold = 1 with cpu_req and dbu_req both high -> only DBU is served; cpu_ack stays 0 until dbu_hold = 0, then the CPU is granted next.
REQ-039 Reset mid-write: assert reset in the ACCESS cycle of a CPU write to 0x20 -> mem_we = 0 in that cycle; mem[0x20] is unchanged; no ack; state = IDLE and busy = 0 in the next cycle.
REQ-040 Late change: alter cpu_addr and cpu_wdata in the cycle after the grant -> the memory still sees the originally latched values.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug unit) arbiter in front of a single-port synchronous memory.
// Latency: request sampled in IDLE at cycle T is acknowledged at T+3; one access per 4 cycles.
// Backpressure: requesters hold req until their one-cycle ack; dbu_hold masks the CPU port.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dbu_req,
  input  logic          dbu_we,
  input  logic [AW-1:0] dbu_addr,
  input  logic [DW-1:0] dbu_wdata,
  output logic [DW-1:0] dbu_rdata,
  output logic          dbu_ack,
  input  logic          dbu_hold,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_dbu
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, DONE} state_t;

  state_t        state_q, state_d;
  logic          last_dbu_q, last_dbu_d;
  logic          grant_dbu_q, grant_dbu_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbu_rdata_q, dbu_rdata_d;

  logic cpu_elig;
  logic dbu_elig;
  logic pick_dbu;

  // The debug unit may always compete; the CPU only while not held off.
  assign cpu_elig = cpu_req & ~dbu_hold;
  assign dbu_elig = dbu_req;
  // DBU wins when it is alone, or on a tie when the CPU was granted last.
  assign pick_dbu = dbu_elig & (~cpu_elig | ~last_dbu_q);

  // Next-state logic: arbitrate and latch the winner in IDLE, capture read data in RESP.
  always_comb begin
    state_d     = state_q;
    last_dbu_d  = last_dbu_q;
    grant_dbu_d = grant_dbu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbu_rdata_d = dbu_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_elig | dbu_elig) begin
          state_d     = ACCESS;
          grant_dbu_d = pick_dbu;
          last_dbu_d  = pick_dbu;
          we_d        = pick_dbu ? dbu_we    : cpu_we;
          addr_d      = pick_dbu ? dbu_addr  : cpu_addr;
          wdata_d     = pick_dbu ? dbu_wdata : cpu_wdata;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = DONE;
        // Memory data for the address driven in ACCESS is valid now.
        if (!we_q) begin
          if (grant_dbu_q) dbu_rdata_d = mem_rdata;
          else             cpu_rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_dbu_q  <= 1'b1;
      grant_dbu_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dbu_q  <= last_dbu_d;
      grant_dbu_q <= grant_dbu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbu_rdata_q <= dbu_rdata_d;
    end
  end

  // The latched address/data only change on a grant, so they also hold the
  // last driven values while idle.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  // Strobes are masked by reset so an aborted access can neither write nor ack.
  assign mem_we    = (state_q == ACCESS) & we_q & ~reset;
  assign busy      = (state_q != IDLE) & ~reset;
  assign cpu_ack   = (state_q == DONE) & ~grant_dbu_q & ~reset;
  assign dbu_ack   = (state_q == DONE) &  grant_dbu_q & ~reset;
  assign grant_dbu = grant_dbu_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbu_rdata = dbu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by a randomized phase.
// A transaction-level reference model queues expected acks and memory writes;
// a monitor on the falling edge pops and compares them against the DUT.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbu_req, dbu_we, dbu_hold;
  logic [AW-1:0] cpu_addr, dbu_addr;
  logic [DW-1:0] cpu_wdata, dbu_wdata;
  logic [DW-1:0] cpu_rdata, dbu_rdata;
  logic          cpu_ack, dbu_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy, grant_dbu;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbu_req(dbu_req), .dbu_we(dbu_we), .dbu_addr(dbu_addr), .dbu_wdata(dbu_wdata),
    .dbu_rdata(dbu_rdata), .dbu_ack(dbu_ack),
    .dbu_hold(dbu_hold),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .grant_dbu(grant_dbu)
  );

  always #5 clk = ~clk;

  // Environment memory seen by the DUT.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; bit port; logic [DW-1:0] rd; } ack_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] dat; } wr_t;
  ack_t expq[$];
  wr_t  wrq[$];

  logic [DW-1:0] ref_mem [256];
  int            cyc = 0;
  bit            model_ok = 0;
  int            m_phase;      // cycles into the current access, 0 = free
  bit            m_last_dbu, m_own, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_dbu_rd;

  // Transaction model: round-robin choice among eligible requesters, then a
  // fixed 4-cycle access whose effects land at known offsets.
  always @(posedge clk) begin
    bit c_ok, d_ok, win;
    cyc = cyc + 1;
    if (reset) begin
      model_ok = 1; m_phase = 0; m_last_dbu = 1; m_own = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dbu_rd = '0;
      expq.delete(); wrq.delete();
    end else if (model_ok) begin
      if (m_phase == 0) begin
        c_ok = cpu_req && !dbu_hold;
        d_ok = dbu_req;
        if (c_ok || d_ok) begin
          if (c_ok && d_ok) win = !m_last_dbu; else win = d_ok;
          m_last_dbu = win; m_own = win;
          m_we    = win ? dbu_we : cpu_we;
          m_addr  = win ? dbu_addr : cpu_addr;
          m_wdata = win ? dbu_wdata : cpu_wdata;
          m_phase = 1;
          if (m_we) wrq.push_back('{cyc, m_addr, m_wdata});
          expq.push_back('{cyc + 2, win,
                           m_we ? (win ? m_dbu_rd : m_cpu_rd) : ref_mem[m_addr]});
        end
      end else if (m_phase == 1) begin
        if (m_we) ref_mem[m_addr] = m_wdata;
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (!m_we) begin
          if (m_own) m_dbu_rd = ref_mem[m_addr]; else m_cpu_rd = ref_mem[m_addr];
        end
        m_phase = 3;
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  ack_t a_exp;
  wr_t  w_exp;
  always @(negedge clk) begin
    if (model_ok) begin
      chk("busy", busy, (m_phase != 0 && !reset));
      if (m_phase != 0 && !reset) chk("grant_dbu", grant_dbu, m_own);
      if ((m_phase == 1 || m_phase == 2) && !reset) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("cpu_rdata", cpu_rdata, m_cpu_rd);
      chk("dbu_rdata", dbu_rdata, m_dbu_rd);
      if (expq.size() > 0 && expq[0].cyc == cyc && !reset) begin
        a_exp = expq.pop_front();
        chk("ack_port", {cpu_ack, dbu_ack}, a_exp.port ? 2'b01 : 2'b10);
        chk("ack_rdata", a_exp.port ? dbu_rdata : cpu_rdata, a_exp.rd);
      end else begin
        chk("no_ack", {cpu_ack, dbu_ack}, 2'b00);
      end
      if (wrq.size() > 0 && wrq[0].cyc == cyc && !reset) begin
        w_exp = wrq.pop_front();
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, w_exp.addr);
        chk("wr_data", mem_wdata, w_exp.dat);
      end else begin
        chk("no_write", mem_we, 1'b0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for any ack; returns at the falling edge where it is seen.
  task automatic wait_ack(input string nm, output bit gc, output bit gd, output bit ok);
    ok = 0; gc = 0; gd = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (cpu_ack || dbu_ack) begin
        gc = cpu_ack; gd = dbu_ack; ok = 1;
        return;
      end
    end
    checks++; errs++;
    $display("FAIL %s: no ack within 24 cycles", nm);
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA5000000 | (i * 32'h00010101);
  endfunction

  initial begin
    bit gc, gd, ok;
    int t0, prev;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_val(i);
      ref_mem[i] = init_val(i);
    end
    mem[8'h10] = 32'h12345678;
    ref_mem[8'h10] = 32'h12345678;

    reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbu_req = 0; dbu_we = 0; dbu_addr = '0; dbu_wdata = '0; dbu_hold = 0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {cpu_ack, dbu_ack, mem_we}, 3'b000);
    chk("rst_rdata", {cpu_rdata, dbu_rdata}, 64'd0);
    chk("rst_grant", grant_dbu, 1'b0);
    reset = 0;

    // CPU read of a preloaded word, with late address/data changes.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    step();
    t0 = cyc;
    chk("rd_mem_addr", mem_addr, 8'h10);
    cpu_addr = 8'h77; cpu_wdata = 32'h11111111;
    wait_ack("rd_ack", gc, gd, ok);
    if (ok) begin
      chk("rd_port", {gc, gd}, 2'b10);
      chk("rd_latency", cyc - t0, 2);
      chk("rd_data", cpu_rdata, 32'h12345678);
    end
    step(); cpu_req = 0;

    // DBU write: one-cycle strobe with the originally latched values.
    dbu_req = 1; dbu_we = 1; dbu_addr = 8'h05; dbu_wdata = 32'hDEADBEEF;
    step();
    chk("wr_strobe", mem_we, 1'b1);
    chk("wr_mem_addr", mem_addr, 8'h05);
    chk("wr_mem_data", mem_wdata, 32'hDEADBEEF);
    dbu_addr = 8'h09; dbu_wdata = 32'h0;
    step();
    chk("wr_one_cycle", mem_we, 1'b0);
    wait_ack("wr_ack", gc, gd, ok);
    if (ok) chk("wr_port", {gc, gd}, 2'b01);
    step(); dbu_req = 0; dbu_we = 0;

    // CPU reads back the DBU write.
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h05;
    wait_ack("rb_ack", gc, gd, ok);
    if (ok) chk("rb_data", cpu_rdata, 32'hDEADBEEF);
    step(); cpu_req = 0;

    // Hold: only DBU served while held; CPU wins right after release.
    dbu_hold = 1; cpu_req = 1; cpu_addr = 8'h03; dbu_req = 1; dbu_addr = 8'h04;
    for (int k = 0; k < 3; k++) begin
      wait_ack("hold_ack", gc, gd, ok);
      if (ok) chk("hold_dbu_only", {gc, gd}, 2'b01);
    end
    step(); dbu_hold = 0;
    wait_ack("release_ack", gc, gd, ok);
    if (ok) chk("release_cpu", {gc, gd}, 2'b10);
    step(); cpu_req = 0; dbu_req = 0;

    // Round-robin from reset with both ports requesting continuously.
    reset = 1; cpu_req = 1; dbu_req = 1;
    step(); step(); reset = 0;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("rr_ack", gc, gd, ok);
      if (ok) begin
        chk("rr_order", {gc, gd}, (k % 2) ? 2'b01 : 2'b10);
        if (k > 0) chk("rr_spacing", cyc - prev, 4);
        prev = cyc;
      end
    end
    step(); cpu_req = 0; dbu_req = 0;
    step(); step();

    // Reset during the ACCESS cycle of a CPU write.
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 32'hCAFEF00D;
    step();
    reset = 1;
    #1;
    chk("rstw_mem_we", mem_we, 1'b0);
    step(); reset = 0; cpu_req = 0; cpu_we = 0;
    chk("rstw_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstw_no_ack", {cpu_ack, dbu_ack}, 2'b00);
    end
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    wait_ack("rstw_rb", gc, gd, ok);
    if (ok) chk("rstw_mem_kept", cpu_rdata, init_val(8'h20));
    step(); cpu_req = 0;

    // Randomized traffic, including drops, late changes, hold and resets.
    repeat (1500) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) cpu_req = !cpu_req;
      if ($urandom_range(0, 2) == 0) begin
        cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 8'($urandom_range(0, 15));
        cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) dbu_req = !dbu_req;
      if ($urandom_range(0, 2) == 0) begin
        dbu_we = 1'($urandom_range(0, 1));
        dbu_addr = 8'($urandom_range(0, 15));
        dbu_wdata = $urandom;
      end
      if ($urandom_range(0, 15) == 0) dbu_hold = !dbu_hold;
    end

    step();
    reset = 0; cpu_req = 0; dbu_req = 0; dbu_hold = 0;
    repeat (8) step();
    chk("drain_acks", expq.size(), 0);
    chk("drain_writes", wrq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
